// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and helpers for the SRAM-like memory port arbiter.
package sram_like_pkg;

    // Transaction FSM states; RESP waits for the downstream data phase.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Access size encodings carried on ch_size / m_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the upstream channel bus and the shared downstream memory port.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sram_like_arbiter_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SW = DATA_W / 8;

    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_wr;
    logic [2*NCH-1:0]      ch_size;
    logic [ADDR_W*NCH-1:0] ch_addr;
    logic [DATA_W*NCH-1:0] ch_wdata;
    logic [SW*NCH-1:0]     ch_wstrb;
    logic [NCH-1:0]        ch_addr_ok;
    logic [NCH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]     ch_rdata;

    logic                  m_req;
    logic                  m_wr;
    logic [1:0]            m_size;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [SW-1:0]         m_wstrb;
    logic                  m_addr_ok;
    logic                  m_data_ok;
    logic [DATA_W-1:0]     m_rdata;

    modport master (
        input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata, ch_wstrb,
        output ch_addr_ok, ch_data_ok, ch_rdata,
        output m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        output ch_req, ch_wr, ch_size, ch_addr, ch_wdata, ch_wstrb,
        input  ch_addr_ok, ch_data_ok, ch_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wdata, m_wstrb,
        output m_addr_ok, m_data_ok, m_rdata
    );

endinterface

// File: rtl/sram_like_arbiter_rr_arbiter.sv
// Purely combinational request arbiter: fixed priority (lowest index) or
// round-robin starting one past the last winner. Kept standalone so other
// request funnels (e.g. cache refill) can reuse it.
module rr_arbiter
    import sram_like_pkg::*;
#(
    parameter  int NCH     = 2,
    parameter  int RR_MODE = 1,
    localparam int IW      = idxWidth(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grantIdx,
    output logic           anyReq
);

    int   cand;
    logic found;

    // Scan the channels in priority order and take the first requester.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyReq   = |req;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NCH; k++) begin
            if (RR_MODE != 0) begin
                cand = (int'(ptr) + 1 + k) % NCH;
            end else begin
                cand = k;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grantIdx    = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel arbiter funnelling SRAM-like requesters onto one downstream port
// with an addr_ok/data_ok split handshake and a single outstanding access.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_like_arbiter_if.master  bus,
    output logic                 busy
);

    localparam int IW = idxWidth(NCH);
    localparam int SW = DATA_W / 8;

    state_t              state;
    state_t              nextState;
    logic [IW-1:0]       rrPtr;
    logic [IW-1:0]       owner;
    logic                heldWr;
    logic [1:0]          heldSize;
    logic [ADDR_W-1:0]   heldAddr;
    logic [DATA_W-1:0]   heldWdata;
    logic [SW-1:0]       heldWstrb;

    logic [NCH-1:0]      grant;
    logic [IW-1:0]       grantIdx;
    logic                anyReq;
    logic                accept;

    rr_arbiter #(
        .NCH     (NCH),
        .RR_MODE (RR_MODE)
    ) uArb (
        .req      (bus.ch_req),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyReq   (anyReq)
    );

    // Acceptance is suppressed while reset is held so every output reads 0.
    assign accept = (state == IDLE) && anyReq && !rst;
    assign busy   = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Capture the winning channel's request and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr     <= IW'(NCH - 1);
            owner     <= '0;
            heldWr    <= 1'b0;
            heldSize  <= SZ_BYTE;
            heldAddr  <= '0;
            heldWdata <= '0;
            heldWstrb <= '0;
        end else if (accept) begin
            owner     <= grantIdx;
            heldWr    <= bus.ch_wr[grantIdx];
            heldSize  <= bus.ch_size[grantIdx*2 +: 2];
            heldAddr  <= bus.ch_addr[grantIdx*ADDR_W +: ADDR_W];
            heldWdata <= bus.ch_wdata[grantIdx*DATA_W +: DATA_W];
            heldWstrb <= bus.ch_wstrb[grantIdx*SW +: SW];
            if (RR_MODE != 0) begin
                rrPtr <= grantIdx;
            end
        end
    end

    // Next-state logic and all handshake outputs; data_ok/rdata pass straight through.
    always_comb begin
        nextState      = state;
        bus.ch_addr_ok = '0;
        bus.ch_data_ok = '0;
        bus.ch_rdata   = '0;
        bus.m_req      = 1'b0;
        bus.m_wr       = 1'b0;
        bus.m_size     = '0;
        bus.m_addr     = '0;
        bus.m_wdata    = '0;
        bus.m_wstrb    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    bus.ch_addr_ok = grant;
                    nextState      = REQ;
                end
            end
            REQ: begin
                bus.m_req   = 1'b1;
                bus.m_wr    = heldWr;
                bus.m_size  = heldSize;
                bus.m_addr  = heldAddr;
                bus.m_wdata = heldWdata;
                bus.m_wstrb = heldWstrb;
                if (bus.m_addr_ok) begin
                    if (bus.m_data_ok) begin
                        bus.ch_data_ok[owner] = 1'b1;
                        bus.ch_rdata          = bus.m_rdata;
                        nextState             = IDLE;
                    end else begin
                        nextState = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.m_data_ok) begin
                    bus.ch_data_ok[owner] = 1'b1;
                    bus.ch_rdata          = bus.m_rdata;
                    nextState             = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter for the CPU's SRAM-like memory ports.
- Funnels the instruction, data and any extra requesters (e.g. uncached or debug paths) onto one shared downstream memory port.
- Adds what the fixed inst/data SRAM split lacks: channel-count and width generics, selectable fixed-priority or round-robin arbitration, and an addr_ok/data_ok split-transaction handshake with one outstanding access.

Parameters:
- NCH, 2, number of upstream channels (>=1); channel 0 is the instruction port by convention.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ch_req  in  NCH  per-channel request valid
- ch_wr  in  NCH  per-channel write (1) / read (0)
- ch_size  in  2*NCH  per-channel access size (0 = byte, 1 = half, 2 = word)
- ch_addr  in  ADDR_W*NCH  per-channel address, channel i at slice [i*ADDR_W +: ADDR_W]
- ch_wdata  in  DATA_W*NCH  per-channel write data
- ch_wstrb  in  (DATA_W/8)*NCH  per-channel byte strobes
- ch_addr_ok  out  NCH  request accepted, one-cycle pulse to the granted channel
- ch_data_ok  out  NCH  response valid, one-cycle pulse to the owning channel
- ch_rdata  out  DATA_W  read data, broadcast to all channels, qualified by ch_data_ok
- m_req  out  1  downstream request
- m_wr  out  1  downstream write
- m_size  out  2  downstream size
- m_addr  out  ADDR_W  downstream address
- m_wdata  out  DATA_W  downstream write data
- m_wstrb  out  DATA_W/8  downstream byte strobes
- m_addr_ok  in  1  downstream accepted the address
- m_data_ok  in  1  downstream response
- m_rdata  in  DATA_W  downstream read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state = IDLE; all outputs 0; held request registers 0; owner = 0; rr_ptr = NCH-1, so channel 0 wins first.
- IDLE:
  - If any ch_req is high, select grant g via the arbiter.
  - Latch wr/size/addr/wdata/wstrb of g and set owner = g.
  - Pulse ch_addr_ok[g] combinationally in the same cycle; go to REQ.
  - If RR_MODE = 1, set rr_ptr = g.
- Arbitration:
  - Fixed priority: lowest-index requesting channel.
  - Round-robin: first requester searching from (rr_ptr+1) mod NCH, wrapping.
  - A grant is combinational from ch_req and rr_ptr.
- REQ:
  - m_req = 1; m_* are driven from the latched registers and stay stable until m_addr_ok.
  - m_addr_ok & ~m_data_ok: go to RESP.
  - m_addr_ok & m_data_ok in the same cycle: complete directly (see RESP), go to IDLE.
- RESP:
  - m_req = 0.
  - On m_data_ok: ch_data_ok[owner] = 1 and ch_rdata = m_rdata (combinational pass-through), go to IDLE.
  - Writes also complete with m_data_ok; ch_rdata then carries whatever m_rdata is and is don't-care.
- ch_rdata when no data_ok is asserted: 0.
- Outstanding: at most one transaction. No upstream acceptance occurs in any non-IDLE cycle, so the next grant earliest happens in the cycle after completion.
- Latency: with a zero-wait downstream, ch_req to ch_data_ok is 2 cycles (accept in cycle 0, m_addr_ok in cycle 1, m_data_ok in cycle 2); the same-cycle addr_ok/data_ok case gives 1 cycle.
- Upstream contract:
  - A channel holds ch_req and its fields until it sees ch_addr_ok.
  - A channel deasserting ch_req before grant is legal: the request is simply not taken.
- Spurious m_data_ok in IDLE or REQ-without-addr_ok is ignored; no channel pulses.
- Reset mid-transaction: immediate return to IDLE, the transaction is dropped, and no data_ok is issued afterwards.
- NCH = 1: the arbiter degenerates to pass-through with the same FSM; rr_ptr stays 0.

Decomposition:
- Package sram_like_pkg holds:
  - state enum IDLE/REQ/RESP, 2-bit encoding;
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - a clog2-based width helper for owner/rr_ptr.
- Sub-module rr_arbiter (parameters NCH, RR_MODE): inputs req[NCH] and ptr; outputs a one-hot grant and an encoded index plus any_req. It is purely combinational, so it can be reused by future cache refill arbitration.

Test Plan:
- Single read, NCH = 2, zero-wait memory: ch_req[0] = 1, addr 0xBFC00000, m_rdata 0x3C1D0001 -> ch_addr_ok[0] at cycle 0, m_req/m_addr = 0xBFC00000 at cycle 1, ch_data_ok[0] with ch_rdata = 0x3C1D0001 at cycle 2; busy high in cycles 1-2.
- Simultaneous requests, RR_MODE = 1: both channels hold req for 4 transactions -> grant order 0, 1, 0, 1. With RR_MODE = 0 the order is 0, 0, 0, 0 while channel 0 keeps requesting.
- Write with 3-cycle downstream wait: ch_wr[1] = 1, addr 0x1FAF0000, wstrb 4'b0011, wdata 0x0000BEEF -> m_* held stable for 3 cycles until m_addr_ok; exactly one ch_data_ok[1] pulse; no ch_addr_ok to channel 0 meanwhile.
- Same-cycle m_addr_ok & m_data_ok in REQ -> ch_data_ok[owner] in that cycle, FSM back to IDLE, next grant in the following cycle.
- Reset asserted in RESP -> all outputs 0 immediately (asynchronous); a later m_data_ok produces no ch_data_ok pulse; after release, channel 0 wins first.
- NCH = 4, RR_MODE = 1: requests on channels 3 and 1 with rr_ptr = 1 -> channel 3 is granted first, then channel 1.
